// File: rtl/mult_share_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mult_share_arbiter_if                                           |
// | Purpose  : Requester bus plus shared-multiplier handshake for the arbiter; |
// |            err exists only when MULT_ARB_TIMEOUT_EN is defined.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface mult_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] md_in;
    logic [NREQ*WIDTH-1:0] mr_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [2*WIDTH-1:0]    prod_out;
    logic                  busy;
    logic                  mult_start;
    logic [WIDTH-1:0]      mult_md;
    logic [WIDTH-1:0]      mult_mr;
    logic                  mult_done;
    logic [2*WIDTH-1:0]    mult_prod;
`ifdef MULT_ARB_TIMEOUT_EN
    logic                  err;
`endif

    // Arbiter side
    modport slave (
        input  req, md_in, mr_in, mult_done, mult_prod,
`ifdef MULT_ARB_TIMEOUT_EN
        output err,
`endif
        output gnt, ack, prod_out, busy, mult_start, mult_md, mult_mr
    );

    // Requesters and multiplier side
    modport master (
        output req, md_in, mr_in, mult_done, mult_prod,
`ifdef MULT_ARB_TIMEOUT_EN
        input  err,
`endif
        input  gnt, ack, prod_out, busy, mult_start, mult_md, mult_mr
    );
endinterface
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mult_share_arbiter                                              |
// | Purpose  : Round-robin sharing of one start/done multiplier among NREQ     |
// |            requesters. Optional WAIT timeout via MULT_ARB_TIMEOUT_EN.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mult_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 4
`ifdef MULT_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 32
`endif
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mult_share_arbiter_if.slave bus
);

    localparam int              PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0]     c_NREQ = (PW+1)'(NREQ);
    localparam logic [PW-1:0]   c_LAST = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_win;
    logic [NREQ-1:0]    r_gnt;
    logic [WIDTH-1:0]   r_md;
    logic [WIDTH-1:0]   r_mr;
    logic [2*WIDTH-1:0] r_prod;

    logic               w_any;
    logic [PW-1:0]      w_win;
    logic [NREQ-1:0]    w_onehot;
    logic [WIDTH-1:0]   w_md;
    logic [WIDTH-1:0]   w_mr;
    logic [PW:0]        w_sum;
    logic               w_tmo;

    // Scan from r_ptr upward with wrap; the first asserted request wins.
    always_comb begin
        w_any    = 1'b0;
        w_win    = '0;
        w_onehot = '0;
        w_md     = '0;
        w_mr     = '0;
        w_sum    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= c_NREQ) begin
                w_sum = w_sum - c_NREQ;
            end
            if (!w_any && bus.req[w_sum[PW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_sum[PW-1:0];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_any && (w_win == PW'(i))) begin
                w_onehot[i] = 1'b1;
                w_md        = bus.md_in[i*WIDTH +: WIDTH];
                w_mr        = bus.mr_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (bus.mult_done || w_tmo) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_win  <= '0;
            r_gnt  <= '0;
            r_md   <= '0;
            r_mr   <= '0;
            r_prod <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt <= w_onehot;
                        r_win <= w_win;
                        r_md  <= w_md;
                        r_mr  <= w_mr;
                    end
                end
                S_WAIT: begin
                    if (bus.mult_done) begin
                        r_prod <= bus.mult_prod;
                    end else if (w_tmo) begin
                        r_prod <= '0;
                    end
                end
                S_RESP: begin
                    r_gnt <= '0;
                    r_ptr <= (r_win == c_LAST) ? '0 : r_win + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int            CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_TMO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // r_cnt counts completed WAIT cycles; the TIMEOUT-th one without done expires.
    assign w_tmo = (r_state == S_WAIT) && (r_cnt == c_TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_WAIT) begin
                if (bus.mult_done) begin
                    r_err <= 1'b0;
                end else if (w_tmo) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.err = r_err;
`else
    assign w_tmo = 1'b0;
`endif

    assign bus.gnt        = r_gnt;
    assign bus.ack        = (r_state == S_RESP) ? r_gnt : '0;
    assign bus.prod_out   = r_prod;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.mult_start = (r_state == S_ISSUE);
    assign bus.mult_md    = r_md;
    assign bus.mult_mr    = r_mr;

endmodule
`default_nettype wire
